// File: rtl/game_display_pkg.sv
// Shared types and the 5x7 font for the game display renderer.
// Font rows are stored top to bottom; bit 4 of each row is the leftmost column.
package game_display_pkg;

  typedef enum logic [2:0] {
    BLANK = 3'd0,
    ONE   = 3'd1,
    TWO   = 3'd2,
    THREE = 3'd3,
    FOUR  = 3'd4,
    CHECK = 3'd5,
    CROSS = 3'd6,
    OVER  = 3'd7
  } disp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2,
    ST_FIN   = 2'd3
  } render_state_e;

  localparam int GLYPH_W = 5;
  localparam int GLYPH_H = 7;

  localparam logic [0:7][0:6][4:0] FONT = '{
    '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000},
    '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
    '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
    '{5'b11110, 5'b00001, 5'b00001, 5'b01110, 5'b00001, 5'b00001, 5'b11110},
    '{5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
    '{5'b00000, 5'b00001, 5'b00001, 5'b00010, 5'b10100, 5'b01000, 5'b00000},
    '{5'b00000, 5'b10001, 5'b01010, 5'b00100, 5'b01010, 5'b10001, 5'b00000},
    '{5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01110}
  };

  // Addresses past the glyph edge read as background.
  function automatic logic font_bit(input logic [2:0] code, input logic [2:0] row,
                                    input logic [2:0] col);
    logic bit_v;
    if ((row < 3'(GLYPH_H)) && (col < 3'(GLYPH_W))) begin
      bit_v = FONT[code][row][3'd4 - col];
    end else begin
      bit_v = 1'b0;
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/game_display_renderer_glyph_rom.sv
// Combinational font lookup: (code, row, col) -> foreground bit.
module glyph_rom
  import game_display_pkg::*;
(
  input  logic [2:0] code,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       pix
);

  assign pix = font_bit(code, row, col);

endmodule

// File: rtl/game_display_renderer.sv
// Paints a scaled glyph box or blanks the whole frame, one pixel write per cycle.
// Requests are captured every cycle and served between sweeps; clear wins over glyph.
module game_display_renderer
  import game_display_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SCALE    = 16,
  parameter int X0       = 280,
  parameter int Y0       = 184
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] display,
  input  logic       clear,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pixel_color,
  output logic       pixel_write,
  output logic       busy,
  output logic       done
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [9:0] X_SCR_LAST = 10'(SCREEN_W - 1);
  localparam logic [8:0] Y_SCR_LAST = 9'(SCREEN_H - 1);
  localparam logic [9:0] X_FIRST    = 10'(X0);
  localparam logic [9:0] X_BOX_LAST = 10'(X0 + GLYPH_W * SCALE - 1);
  localparam logic [8:0] Y_FIRST    = 9'(Y0);
  localparam logic [8:0] Y_BOX_LAST = 9'(Y0 + GLYPH_H * SCALE - 1);

  render_state_e    state_r;
  logic [2:0]       last_code_r, req_code_r, cur_code_r;
  logic             pend_clear_r, pend_glyph_r;
  logic [SUB_W-1:0] sub_x_r, sub_y_r;
  logic [2:0]       col_r, row_r;

  logic             row_end_s, frame_end_s, glyph_bit_s;
  logic [9:0]       nxt_x_s;
  logic [8:0]       nxt_y_s;
  logic [SUB_W-1:0] nxt_sub_x_s, nxt_sub_y_s;
  logic [2:0]       nxt_col_s, nxt_row_s, rom_code_s, ref_code_s;

  // Next raster position and the code a new display value is compared against.
  always_comb begin
    row_end_s   = (state_r == ST_CLEAR) ? (x == X_SCR_LAST) : (x == X_BOX_LAST);
    frame_end_s = row_end_s && ((state_r == ST_CLEAR) ? (y == Y_SCR_LAST) : (y == Y_BOX_LAST));
    nxt_x_s     = x;
    nxt_y_s     = y;
    nxt_sub_x_s = sub_x_r;
    nxt_sub_y_s = sub_y_r;
    nxt_col_s   = col_r;
    nxt_row_s   = row_r;
    if (state_r == ST_IDLE) begin
      nxt_x_s     = X_FIRST;
      nxt_y_s     = Y_FIRST;
      nxt_sub_x_s = {SUB_W{1'b0}};
      nxt_sub_y_s = {SUB_W{1'b0}};
      nxt_col_s   = 3'd0;
      nxt_row_s   = 3'd0;
    end else if (row_end_s) begin
      nxt_x_s     = (state_r == ST_CLEAR) ? 10'd0 : X_FIRST;
      nxt_y_s     = y + 9'd1;
      nxt_sub_x_s = {SUB_W{1'b0}};
      nxt_col_s   = 3'd0;
      if (sub_y_r == SUB_LAST) begin
        nxt_sub_y_s = {SUB_W{1'b0}};
        nxt_row_s   = row_r + 3'd1;
      end else begin
        nxt_sub_y_s = sub_y_r + {{(SUB_W-1){1'b0}}, 1'b1};
      end
    end else begin
      nxt_x_s = x + 10'd1;
      if (sub_x_r == SUB_LAST) begin
        nxt_sub_x_s = {SUB_W{1'b0}};
        nxt_col_s   = col_r + 3'd1;
      end else begin
        nxt_sub_x_s = sub_x_r + {{(SUB_W-1){1'b0}}, 1'b1};
      end
    end
    rom_code_s = (state_r == ST_IDLE) ? req_code_r : cur_code_r;
    // The code being launched or drawn counts as current, so it is not re-requested.
    case (state_r)
      ST_IDLE: ref_code_s = (!pend_clear_r && pend_glyph_r) ? req_code_r : last_code_r;
      ST_DRAW: ref_code_s = cur_code_r;
      default: ref_code_s = last_code_r;
    endcase
  end

  glyph_rom u_glyph_rom (
    .code (rom_code_s),
    .row  (nxt_row_s),
    .col  (nxt_col_s),
    .pix  (glyph_bit_s)
  );

  // Sweep FSM with registered pixel outputs plus per-cycle request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      last_code_r  <= 3'd0;
      req_code_r   <= 3'd0;
      cur_code_r   <= 3'd0;
      pend_clear_r <= 1'b1;
      pend_glyph_r <= 1'b0;
      sub_x_r      <= {SUB_W{1'b0}};
      sub_y_r      <= {SUB_W{1'b0}};
      col_r        <= 3'd0;
      row_r        <= 3'd0;
      x            <= 10'd0;
      y            <= 9'd0;
      pixel_color  <= 1'b0;
      pixel_write  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pend_clear_r) begin
            state_r      <= ST_CLEAR;
            pend_clear_r <= 1'b0;
            x            <= 10'd0;
            y            <= 9'd0;
            pixel_color  <= 1'b0;
            pixel_write  <= 1'b1;
            busy         <= 1'b1;
          end else if (pend_glyph_r) begin
            state_r      <= ST_DRAW;
            cur_code_r   <= req_code_r;
            pend_glyph_r <= 1'b0;
            x            <= nxt_x_s;
            y            <= nxt_y_s;
            sub_x_r      <= nxt_sub_x_s;
            sub_y_r      <= nxt_sub_y_s;
            col_r        <= nxt_col_s;
            row_r        <= nxt_row_s;
            pixel_color  <= glyph_bit_s;
            pixel_write  <= 1'b1;
            busy         <= 1'b1;
          end else begin
            pixel_write <= 1'b0;
          end
        end
        ST_CLEAR, ST_DRAW: begin
          if (frame_end_s) begin
            state_r     <= ST_FIN;
            pixel_write <= 1'b0;
            pixel_color <= 1'b0;
            done        <= 1'b1;
            if (state_r == ST_CLEAR) begin
              last_code_r <= 3'd0;
              if (display != 3'd0) begin
                pend_glyph_r <= 1'b1;
                req_code_r   <= display;
              end
            end else begin
              last_code_r <= cur_code_r;
            end
          end else begin
            x           <= nxt_x_s;
            y           <= nxt_y_s;
            sub_x_r     <= nxt_sub_x_s;
            sub_y_r     <= nxt_sub_y_s;
            col_r       <= nxt_col_s;
            row_r       <= nxt_row_s;
            pixel_color <= (state_r == ST_DRAW) ? glyph_bit_s : 1'b0;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          pixel_write <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
      if (clear) begin
        pend_clear_r <= 1'b1;
      end
      if (display != ref_code_s) begin
        pend_glyph_r <= 1'b1;
        req_code_r   <= display;
      end
    end
  end

  game_display_renderer_chk #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .SCALE    (SCALE),
    .X0       (X0),
    .Y0       (Y0)
  ) u_chk (
    .clk   (clk),
    .reset (reset)
  );

endmodule

// Parameter sanity: the glyph box must lie on a screen addressable by x and y.
module game_display_renderer_chk
  import game_display_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SCALE    = 16,
  parameter int X0       = 280,
  parameter int Y0       = 184
) (
  input logic clk,
  input logic reset
);

  localparam bit BOX_OK = (SCALE >= 1) && (X0 >= 0) && (Y0 >= 0) &&
                          (SCREEN_W <= 1024) && (SCREEN_H <= 512) &&
                          (X0 + GLYPH_W * SCALE <= SCREEN_W) &&
                          (Y0 + GLYPH_H * SCALE <= SCREEN_H);

  a_box_fits: assert property (@(posedge clk) disable iff (!reset) BOX_OK);

endmodule

// File: tb/tb_game_display_renderer.sv
// Directed bench: a queue of expected pixel writes built from the glyph rules is
// compared against every DUT write; a shadow frame buffer pins literal pixels.
module tb_game_display_renderer;

  localparam int W = 16, H = 12, SC = 1, BX = 2, BY = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] display = 3'd0;
  logic       clear = 1'b0;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_color, pixel_write, busy, done;

  game_display_renderer #(
    .SCREEN_W (W), .SCREEN_H (H), .SCALE (SC), .X0 (BX), .Y0 (BY)
  ) dut (
    .clk (clk), .reset (reset), .display (display), .clear (clear),
    .x (x), .y (y), .pixel_color (pixel_color), .pixel_write (pixel_write),
    .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  typedef struct { int px; int py; logic c; } wr_t;
  wr_t  exp_q[$];
  int   checks = 0, errors = 0;
  int   wr_cnt = 0, done_cnt = 0, cyc = 0, last_wr_cyc = -100;
  logic fb [W][H];

  function automatic logic [34:0] glyph(input int c);
    case (c)
      1: return 35'b00100_01100_00100_00100_00100_00100_01110;
      2: return 35'b01110_10001_00001_00010_00100_01000_11111;
      3: return 35'b11110_00001_00001_01110_00001_00001_11110;
      4: return 35'b00010_00110_01010_10010_11111_00010_00010;
      5: return 35'b00000_00001_00001_00010_10100_01000_00000;
      6: return 35'b00000_10001_01010_00100_01010_10001_00000;
      7: return 35'b01110_10001_10000_10111_10001_10001_01110;
      default: return 35'd0;
    endcase
  endfunction

  function automatic logic model_bit(input int c, input int r, input int col);
    logic [34:0] g;
    g = glyph(c);
    return g[34 - (r * 5 + col)];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_clear();
    wr_t e;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        e.px = xx; e.py = yy; e.c = 1'b0;
        exp_q.push_back(e);
      end
  endtask

  task automatic push_glyph(input int c);
    wr_t e;
    for (int yy = 0; yy < 7 * SC; yy++)
      for (int xx = 0; xx < 5 * SC; xx++) begin
        e.px = BX + xx; e.py = BY + yy; e.c = model_bit(c, yy / SC, xx / SC);
        exp_q.push_back(e);
      end
  endtask

  task automatic settle(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout remaining=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    #1;
    check({name, "_busy_idle"}, busy, 0);
  endtask

  task automatic wait_writes(input string name, input int target, input int budget);
    int i;
    i = 0;
    while (wr_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (wr_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_wait writes=%0d expected=%0d", name, wr_cnt, target);
    end
  endtask

  // Compare every write against the expected queue and time every done pulse.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (pixel_write) begin
          wr_cnt++;
          last_wr_cyc = cyc;
          check("busy_while_write", busy, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write at x=%0d y=%0d expected=no write", x, y);
          end else begin
            e = exp_q.pop_front();
            check("wr_x", x, e.px);
            check("wr_y", y, e.py);
            check("wr_color", pixel_color, e.c);
          end
          if (x < W && y < H) fb[x][y] = pixel_color;
        end
        if (done) begin
          done_cnt++;
          check("done_after_last_write", cyc - last_wr_cyc, 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int base, dbase, ones;
    logic [4:0] row9;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) fb[i][j] = 1'b1;

    // Reset state, then the power-up clear.
    @(negedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", pixel_color, 0);
    check("rst_write", pixel_write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    push_clear();
    @(negedge clk);
    #2 reset = 1'b1;
    settle("s1", 600);
    check("s1_writes", wr_cnt, 192);
    check("s1_done", done_cnt, 1);
    ones = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) ones += int'(fb[i][j]);
    check("s1_blank_screen", ones, 0);

    // Digit "1".
    base = wr_cnt;
    @(negedge clk);
    display = 3'd1;
    push_glyph(1);
    settle("s2", 200);
    check("s2_writes", wr_cnt - base, 35);
    check("s2_pix_4_3", fb[4][3], 1);
    check("s2_pix_2_3", fb[2][3], 0);
    row9 = 5'b01110;
    for (int i = 0; i < 5; i++) check("s2_row9", fb[2 + i][9], row9[4 - i]);

    // Game-over glyph, so the next "1" is a fresh request.
    @(negedge clk);
    display = 3'd7;
    push_glyph(7);
    settle("s2g", 200);

    // Codes 2 then 3 arrive during the "1" sweep: only 3 follows.
    base = wr_cnt;
    dbase = done_cnt;
    @(negedge clk);
    display = 3'd1;
    push_glyph(1);
    wait_writes("s3", base + 5, 100);
    display = 3'd2;
    repeat (3) @(negedge clk);
    display = 3'd3;
    push_glyph(3);
    settle("s3", 300);
    check("s3_writes", wr_cnt - base, 70);
    check("s3_done", done_cnt - dbase, 2);
    check("s3_pix_2_3", fb[2][3], 1);
    check("s3_pix_2_4", fb[2][4], 0);
    check("s3_pix_6_4", fb[6][4], 1);

    // Clear pulse mid-draw of 4: draw, clear, redraw.
    base = wr_cnt;
    dbase = done_cnt;
    @(negedge clk);
    display = 3'd4;
    push_glyph(4);
    wait_writes("s4", base + 10, 100);
    clear = 1'b1;
    push_clear();
    push_glyph(4);
    @(negedge clk);
    clear = 1'b0;
    settle("s4", 800);
    check("s4_writes", wr_cnt - base, 262);
    check("s4_done", done_cnt - dbase, 3);
    check("s4_pix_5_3", fb[5][3], 1);
    check("s4_pix_2_3", fb[2][3], 0);

    // Reset mid-draw of the check mark.
    dbase = done_cnt;
    base = wr_cnt;
    @(negedge clk);
    display = 3'd5;
    push_glyph(5);
    wait_writes("s5", base + 10, 100);
    #2 reset = 1'b0;
    #1;
    check("s5_rst_write", pixel_write, 0);
    check("s5_rst_busy", busy, 0);
    exp_q.delete();
    push_clear();
    push_glyph(5);
    @(negedge clk);
    #2 reset = 1'b1;
    settle("s5", 800);
    check("s5_done", done_cnt - dbase, 2);
    check("s5_pix_6_4", fb[6][4], 1);
    check("s5_pix_2_7", fb[2][7], 1);
    check("s5_pix_4_3", fb[4][3], 0);

    // Holding the drawn code produces no traffic.
    base = wr_cnt;
    repeat (500) @(negedge clk);
    #1;
    check("s6_writes", wr_cnt - base, 0);
    check("s6_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_display_renderer.md
Name: game_display_renderer

Overview:
- Consumer end of the memory game's display interface: takes the 3-bit `display` select and `clear` request and paints the frame buffer.
- Draws a scaled 5x7 glyph into a fixed box, or blanks the whole screen, by issuing one pixel write per cycle to the VGA frame-buffer write port.
- Sits between the game top level and the frame-buffer writer; it has no knowledge of game state.

Parameters:
- SCREEN_W, 640: frame width in pixels.
- SCREEN_H, 480: frame height in pixels.
- SCALE, 16: glyph pixel replication factor; the box is 5*SCALE wide by 7*SCALE tall.
- X0, 280: glyph box left column.
- Y0, 184: glyph box top row.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- display  in  3  glyph select: 0 blank, 1-4 digits "1"-"4", 5 check mark, 6 cross, 7 "G" (game over).
- clear  in  1  request full-screen blank; level-sampled.
- x  out  10  write column.
- y  out  9  write row.
- pixel_color  out  1  1 = foreground, 0 = background.
- pixel_write  out  1  write strobe; x, y and pixel_color are valid when high.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last pixel of any sweep.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0; last_code=0; pend_clear=1; pend_glyph=0.
  - Reset asserted mid-sweep forces pixel_write=0 and busy=0 immediately and abandons the sweep.
  - A full clear runs after release.
- Request capture, every cycle:
  - clear=1 sets pend_clear.
  - display != last_code sets pend_glyph and latches req_code=display. The latest value wins, so intermediate codes that arrive while busy are dropped.
- FSM states: IDLE, CLEAR, DRAW, FIN.
- IDLE:
  - If pend_clear, go to CLEAR and clear pend_clear. Clear has priority.
  - Otherwise, if pend_glyph, go to DRAW with cur_code=req_code and clear pend_glyph.
  - The first pixel_write is asserted the cycle after the FSM leaves IDLE (registered outputs).
- CLEAR:
  - Raster sweep with x fastest, x 0..SCREEN_W-1 and y 0..SCREEN_H-1, pixel_color=0: SCREEN_W*SCREEN_H writes.
  - On completion, set last_code=0. If display != 0, set pend_glyph (redraw after clear).
- DRAW:
  - Raster sweep of the box, x X0..X0+5*SCALE-1 and y Y0..Y0+7*SCALE-1.
  - pixel_color = font bit at row (y-Y0)/SCALE, column (x-X0)/SCALE. Every box pixel is written, so the previous glyph is erased.
  - Code 0 writes the whole box as 0.
  - On completion, set last_code=cur_code.
  - Use per-axis sub-counters 0..SCALE-1; no dividers.
- FIN: done=1 for one cycle, then return to IDLE.
- busy is 1 in CLEAR, DRAW and FIN.
- Boundaries:
  - Requests arriving during a sweep never interrupt it.
  - clear and a display change in the same cycle: clear is performed first, then the glyph.
  - display returning to last_code before the sweep starts still redraws once, because pend_glyph is already set.
  - Counters saturate exactly at the last pixel, with no wrap past the box or the screen.
- Width: x and y are zero-extended. The box must fit on screen; an out-of-range configuration is a parameter error checked by an assertion.

Decomposition:
- Package game_display_pkg:
  - display code enum (BLANK, ONE..FOUR, CHECK, CROSS, OVER);
  - glyph dimension constants GLYPH_W=5, GLYPH_H=7;
  - 8x7x5 font bitmap constant, bit 4 = leftmost column.
- Digit "1" rows: 00100, 01100, 00100, 00100, 00100, 00100, 01110.
- Sub-module glyph_rom: combinational (code, row, col) -> bit.

Test Plan (bench params SCREEN_W=16, SCREEN_H=12, SCALE=1, X0=2, Y0=3):
- Reset release with display=0 -> 192 writes, all color 0, first (0,0), last (15,11); done pulse on the next cycle; busy=0 afterwards.
- display=1 after the clear -> exactly 35 writes at x 2..6 and y 3..9. (4,3)=1, (2,3)=0, and row y=9 is 0,1,1,1,0. last_code=1.
- During the "1" draw, display goes 2 then 3 -> the "1" sweep completes, followed by exactly one 35-write sweep with the code-3 bitmap; code 2 is never drawn.
- clear pulsed mid-draw of code 4 -> the draw finishes, then the 192-write clear, then a redraw of code 4 because display is still 4. There are three done pulses in total.
- Reset asserted at write 10 of a draw -> pixel_write=0 in the same cycle. After release, a full clear and then a redraw of the current nonzero display.
- display held at the drawn code for 500 cycles with clear=0 -> zero writes, busy=0.
